// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and constants for the 2x2 matrix multiply sequencer
package matmul_pkg;

    localparam int DW_DEFAULT    = 18;
    localparam int ACC_W_DEFAULT = 2 * DW_DEFAULT + 1;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/matmul_if.sv
// rtl/matmul_if.sv - controller handshake plus matrix memory port bundle
interface matmul_if #(
    parameter int DW = matmul_pkg::DW_DEFAULT
) ();
    logic          start;
    logic          busy;
    logic          done;
    logic          ovf;
    logic [1:0]    mem_sel;
    logic [1:0]    mem_addr;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // master: controller and memory side; slave: the multiply sequencer
    modport master (
        output start, mem_rdata,
        input  busy, done, ovf, mem_sel, mem_addr, mem_wr, mem_wdata
    );

    modport slave (
        input  start, mem_rdata,
        output busy, done, ovf, mem_sel, mem_addr, mem_wr, mem_wdata
    );
endinterface

// File: rtl/matmul_mac.sv
// rtl/matmul_mac.sv - operand latch and clearable multiply-accumulate register
module matmul_mac #(
    parameter int DW    = matmul_pkg::DW_DEFAULT,
    parameter int ACC_W = 2 * DW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          ld_a_i,
    input  logic          acc_en_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] acc_lo_o,
    output logic          ovf_o
);
    logic [DW-1:0]    a_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [2*DW-1:0]  prod;

    always_comb begin
        prod  = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, din_i};
        acc_d = acc_q + ACC_W'(prod);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            acc_q <= '0;
        end else begin
            if (ld_a_i) begin
                a_q <= din_i;
            end
            if (clr_i) begin
                acc_q <= '0;
            end else if (acc_en_i) begin
                acc_q <= acc_d;
            end
        end
    end

    // any bit above the stored word means the written element wrapped
    assign acc_lo_o = acc_q[DW-1:0];
    assign ovf_o    = |acc_q[ACC_W-1:DW];

endmodule

// File: rtl/matmul_ctrl.sv
// rtl/matmul_ctrl.sv - sequencer computing C = A x B (2x2) over the matrix memory port
module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int N     = 2,
    parameter int ACC_W = 2 * DW + 1
) (
    input  logic     clk,
    input  logic     rst,
    matmul_if.slave  ctrl_if
);
    localparam logic LAST = 1'(N - 1);

    state_t state_q, state_d;
    logic   i_q, i_d;
    logic   j_q, j_d;
    logic   k_q, k_d;
    logic   ovf_q, ovf_d;

    logic          mac_clr;
    logic          mac_ld_a;
    logic          mac_en;
    logic [DW-1:0] mac_acc_lo;
    logic          mac_ovf;

    matmul_mac #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (mac_clr),
        .ld_a_i   (mac_ld_a),
        .acc_en_i (mac_en),
        .din_i    (ctrl_if.mem_rdata),
        .acc_lo_o (mac_acc_lo),
        .ovf_o    (mac_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= 1'b0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (ctrl_if.start) begin
                    state_d = RD_A;
                    i_d     = 1'b0;
                    j_d     = 1'b0;
                    k_d     = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            RD_A: state_d = RD_B;
            RD_B: begin
                if (k_q == LAST) begin
                    state_d = WR;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = RD_A;
                end
            end
            WR: begin
                ovf_d = ovf_q | mac_ovf;
                k_d   = 1'b0;
                // element order is row-major: 00, 01, 10, 11
                if ({i_q, j_q} == {LAST, LAST}) begin
                    state_d = DONE;
                end else begin
                    {i_d, j_d} = {i_q, j_q} + 2'd1;
                    state_d    = RD_A;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ctrl_if.busy      = (state_q != IDLE);
        ctrl_if.done      = 1'b0;
        ctrl_if.mem_sel   = SEL_A;
        ctrl_if.mem_addr  = 2'b00;
        ctrl_if.mem_wr    = 1'b0;
        ctrl_if.mem_wdata = '0;
        mac_clr           = 1'b0;
        mac_ld_a          = 1'b0;
        mac_en            = 1'b0;
        case (state_q)
            IDLE: mac_clr = ctrl_if.start;
            RD_A: begin
                ctrl_if.mem_sel  = SEL_A;
                ctrl_if.mem_addr = {i_q, k_q};
                mac_ld_a         = 1'b1;
            end
            RD_B: begin
                ctrl_if.mem_sel  = SEL_B;
                ctrl_if.mem_addr = {k_q, j_q};
                mac_en           = 1'b1;
            end
            WR: begin
                ctrl_if.mem_sel   = SEL_C;
                ctrl_if.mem_addr  = {i_q, j_q};
                ctrl_if.mem_wr    = 1'b1;
                ctrl_if.mem_wdata = mac_acc_lo;
                mac_clr           = 1'b1;
            end
            DONE:    ctrl_if.done = 1'b1;
            default: ;
        endcase
    end

    assign ctrl_if.ovf = ovf_q;

endmodule

// File: tb/tb_matmul_ctrl.sv
// tb/tb_matmul_ctrl.sv - scoreboard bench for matmul_ctrl with a behavioural matrix memory
module tb_matmul_ctrl;
    import matmul_pkg::*;

    localparam int DW    = 18;
    localparam int ACC_W = 2 * DW + 1;

    typedef struct {
        int            cyc;
        logic [1:0]    addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matmul_if #(.DW(DW)) bus ();

    matmul_ctrl #(.DW(DW), .N(2), .ACC_W(ACC_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_if (bus)
    );

    logic [DW-1:0] mem_a [4];
    logic [DW-1:0] mem_b [4];
    logic [DW-1:0] mem_c [4];

    assign bus.mem_rdata = (bus.mem_sel == SEL_A) ? mem_a[bus.mem_addr] :
                           (bus.mem_sel == SEL_B) ? mem_b[bus.mem_addr] : '0;

    always @(posedge clk) begin
        if (bus.mem_wr && bus.mem_sel == SEL_C) begin
            mem_c[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  wr_cnt, done_cnt, done_cyc, post_rst_act;
    bit  model_ovf;

    task automatic set_ops(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b);
        for (int n = 0; n < 4; n++) begin
            mem_a[n] = a[n*DW +: DW];
            mem_b[n] = b[n*DW +: DW];
        end
    endtask

    task automatic push_expected(input int base);
        logic [ACC_W-1:0] acc;
        wr_t e;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                acc = '0;
                for (int k = 0; k < 2; k++) begin
                    acc = acc + ACC_W'(mem_a[2*i+k]) * ACC_W'(mem_b[2*k+j]);
                end
                e.cyc  = base + 5 * (2*i + j + 1);
                e.addr = 2'(2*i + j);
                e.data = acc[DW-1:0];
                exp_q.push_back(e);
                if (acc[ACC_W-1:DW] != 0) model_ovf = 1'b1;
            end
        end
    endtask

    // entered at a negedge: that half-cycle is cycle 0, so smask[0] is the launching start
    task automatic observe(input int ncyc, input logic [63:0] smask, input int rst_cyc);
        wr_t e;
        wr_cnt       = 0;
        done_cnt     = 0;
        done_cyc     = -1;
        post_rst_act = 0;
        bus.start    = smask[0];
        rst          = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            bus.start = smask[c];
            rst       = (c == rst_cyc);
            @(negedge clk);
            if (rst_cyc > 0 && c > rst_cyc && (bus.busy || bus.mem_wr)) post_rst_act++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (bus.mem_wr === 1'b1) begin
                wr_cnt++;
                checks++;
                if (bus.mem_sel !== SEL_C) begin
                    errors++;
                    $display("FAIL wr_sel: cycle %0d got sel %0d want %0d", c, bus.mem_sel, SEL_C);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_write: cycle %0d addr %0d data %0d want no write", c, bus.mem_addr, bus.mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (c != e.cyc || bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
                        errors++;
                        $display("FAIL write: got cycle %0d addr %0d data %0d want cycle %0d addr %0d data %0d",
                                 c, bus.mem_addr, bus.mem_wdata, e.cyc, e.addr, e.data);
                    end
                end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: got %0d left want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.ovf, bus.mem_wr} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {bus.busy, bus.done, bus.ovf, bus.mem_wr});
        end
        checks++;
        if ({bus.mem_sel, bus.mem_addr, bus.mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_port: got sel %0d addr %0d wdata %0d want 0 0 0", bus.mem_sel, bus.mem_addr, bus.mem_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy %b want 0", bus.busy);
        end
    endtask

    task automatic test_basic();
        set_ops({18'd4, 18'd3, 18'd2, 18'd1}, {18'd8, 18'd7, 18'd6, 18'd5});
        model_ovf = 1'b0;
        push_expected(0);
        observe(22, 64'h1, -1);
        checks++;
        if (done_cnt != 1 || done_cyc != 21) begin
            errors++;
            $display("FAIL basic_done: got count %0d cycle %0d want 1 21", done_cnt, done_cyc);
        end
        checks++;
        if (bus.ovf !== model_ovf || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: got ovf %b busy %b want ovf %b busy 0", bus.ovf, bus.busy, model_ovf);
        end
    endtask

    task automatic test_identity();
        logic [DW-1:0] want_c [4];
        want_c = '{18'd9, 18'd8, 18'd7, 18'd6};
        set_ops({18'd1, 18'd0, 18'd0, 18'd1}, {18'd6, 18'd7, 18'd8, 18'd9});
        model_ovf = 1'b0;
        push_expected(0);
        observe(22, 64'h1, -1);
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (mem_c[n] !== want_c[n]) begin
                errors++;
                $display("FAIL identity_c%0d: got %0d want %0d", n, mem_c[n], want_c[n]);
            end
        end
        checks++;
        if (mem_a[0] !== 18'd1 || mem_a[3] !== 18'd1 || mem_b[0] !== 18'd9 || mem_b[3] !== 18'd6) begin
            errors++;
            $display("FAIL identity_ab: got a0 %0d a3 %0d b0 %0d b3 %0d want 1 1 9 6", mem_a[0], mem_a[3], mem_b[0], mem_b[3]);
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] big;
        big = 18'd1 << 17;
        set_ops({big, big, big, big}, {18'd2, 18'd2, 18'd2, 18'd2});
        model_ovf = 1'b0;
        push_expected(0);
        observe(22, 64'h1, -1);
        checks++;
        if (bus.ovf !== 1'b1 || model_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %b want 1", bus.ovf);
        end
    endtask

    task automatic test_ovf_clear();
        set_ops({18'd0, 18'd0, 18'd0, 18'd0}, {18'd0, 18'd0, 18'd0, 18'd0});
        model_ovf = 1'b0;
        push_expected(0);
        observe(22, 64'h1, -1);
        checks++;
        if (bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b want 0", bus.ovf);
        end
    endtask

    task automatic test_start_ignored();
        logic [63:0] m;
        m = 64'h1 | (64'h1 << 3) | (64'h1 << 21) | (64'h1 << 22);
        set_ops({18'd4, 18'd3, 18'd2, 18'd1}, {18'd8, 18'd7, 18'd6, 18'd5});
        push_expected(0);
        push_expected(22);
        observe(44, m, -1);
        checks++;
        if (wr_cnt != 8 || done_cnt != 2 || done_cyc != 21) begin
            errors++;
            $display("FAIL start_ignored: got writes %0d dones %0d first %0d want 8 2 21", wr_cnt, done_cnt, done_cyc);
        end
    endtask

    task automatic test_rst_mid();
        push_expected(0);
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        observe(12, 64'h1, 7);
        checks++;
        if (wr_cnt != 1 || post_rst_act != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL rst_mid: got writes %0d post_rst_act %0d dones %0d want 1 0 0", wr_cnt, post_rst_act, done_cnt);
        end
        checks++;
        if (mem_c[0] !== 18'd19) begin
            errors++;
            $display("FAIL rst_mid_c0: got %0d want 19", mem_c[0]);
        end
        push_expected(0);
        observe(22, 64'h1, -1);
        checks++;
        if (done_cnt != 1 || done_cyc != 21) begin
            errors++;
            $display("FAIL rst_recover: got count %0d cycle %0d want 1 21", done_cnt, done_cyc);
        end
    endtask

    task automatic test_rst_hold();
        rst       = 1'b1;
        bus.start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0 || bus.mem_wr !== 1'b0) begin
                errors++;
                $display("FAIL rst_hold: got busy %b wr %b want 0 0", bus.busy, bus.mem_wr);
            end
        end
        push_expected(0);
        push_expected(22);
        observe(46, (64'h1 << 44) - 64'h1, -1);
        checks++;
        if (wr_cnt != 8 || done_cnt != 2 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL start_held: got writes %0d dones %0d busy %b want 8 2 0", wr_cnt, done_cnt, bus.busy);
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        set_ops('0, '0);
        test_reset();
        test_basic();
        test_identity();
        test_overflow();
        test_ovf_clear();
        test_start_ignored();
        test_rst_mid();
        test_rst_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
